loba_pipe_mult: RTL and testbench

- Parametrised, pipelined leading-one-based approximate (LOBA) unsigned multiplier for the approximate-arithmetic multiplier library.
- Each operand is split into a high and a low W-bit segment around its leading one; up to four segment products are shifted and summed.
- A per-transaction mode selects the approximation level, from high×high only (LOBA0) to all four products.
- Valid/ready handshakes on input and output so it drops into streaming datapaths.

---
 rtl/loba_pipe_mult.sv | 149 ++++++++++++++
 tb/tb_loba_pipe_mult.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/loba_pipe_mult.sv
// rtl/loba_pipe_mult.sv - pipelined leading-one-based approximate unsigned multiplier
module loba_pipe_mult #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p
);
    localparam int SW = $clog2(N);
    localparam int PW = 2 * N;

    // Shift that puts the W-bit window at the leading one; zero when the
    // leading one sits inside the bottom W bits or the value is zero.
    function automatic logic [SW-1:0] seg_shift(input logic [N-1:0] x);
        logic [SW-1:0] s;
        s = '0;
        for (int i = W - 1; i < N; i++) begin
            if (x[i]) s = SW'(i - (W - 1));
        end
        return s;
    endfunction

    function automatic logic [W-1:0] seg_bits(input logic [N-1:0] x, input logic [SW-1:0] s);
        return W'(x >> s);
    endfunction

    // Bits below the high window; empty when the window starts at bit 0.
    function automatic logic [N-1:0] residual(input logic [N-1:0] x, input logic [SW-1:0] s);
        return x & ((N'(1) << s) - N'(1));
    endfunction

    function automatic logic [PW-1:0] term(input logic [2*W-1:0] prod, input logic [SW:0] s);
        return PW'(prod) << s;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [SW-1:0] sha_c, sla_c, shb_c, slb_c;
    logic [N-1:0]  ra_c, rb_c;

    // Split both operands into high and low segments around their leading ones
    always_comb begin
        sha_c = seg_shift(a);
        ra_c  = residual(a, sha_c);
        sla_c = seg_shift(ra_c);
        shb_c = seg_shift(b);
        rb_c  = residual(b, shb_c);
        slb_c = seg_shift(rb_c);
    end

    logic          v1;
    logic [W-1:0]  ah1, al1, bh1, bl1;
    logic [SW-1:0] sha1, sla1, shb1, slb1;
    logic [1:0]    mode1;

    // Stage 1: register segments, their shifts and the transaction mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            ah1   <= '0;
            al1   <= '0;
            bh1   <= '0;
            bl1   <= '0;
            sha1  <= '0;
            sla1  <= '0;
            shb1  <= '0;
            slb1  <= '0;
            mode1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                ah1   <= seg_bits(a, sha_c);
                al1   <= seg_bits(ra_c, sla_c);
                bh1   <= seg_bits(b, shb_c);
                bl1   <= seg_bits(rb_c, slb_c);
                sha1  <= sha_c;
                sla1  <= sla_c;
                shb1  <= shb_c;
                slb1  <= slb_c;
                mode1 <= mode;
            end
        end
    end

    logic           v2;
    logic [2*W-1:0] pr_hh, pr_hl, pr_lh, pr_ll;
    logic [SW:0]    s_hh, s_hl, s_lh, s_ll;
    logic [1:0]     mode2;

    // Stage 2: the four segment products and their combined shift amounts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            pr_hh <= '0;
            pr_hl <= '0;
            pr_lh <= '0;
            pr_ll <= '0;
            s_hh  <= '0;
            s_hl  <= '0;
            s_lh  <= '0;
            s_ll  <= '0;
            mode2 <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                pr_hh <= (2*W)'(ah1) * (2*W)'(bh1);
                pr_hl <= (2*W)'(ah1) * (2*W)'(bl1);
                pr_lh <= (2*W)'(al1) * (2*W)'(bh1);
                pr_ll <= (2*W)'(al1) * (2*W)'(bl1);
                s_hh  <= (SW+1)'(sha1) + (SW+1)'(shb1);
                s_hl  <= (SW+1)'(sha1) + (SW+1)'(slb1);
                s_lh  <= (SW+1)'(sla1) + (SW+1)'(shb1);
                s_ll  <= (SW+1)'(sla1) + (SW+1)'(slb1);
                mode2 <= mode1;
            end
        end
    end

    logic [PW-1:0] sum_c;

    // Shift each product into place and add the ones the mode enables
    always_comb begin
        sum_c = term(pr_hh, s_hh);
        if (mode2 >= 2'd1) sum_c = sum_c + term(pr_hl, s_hl);
        if (mode2 >= 2'd2) sum_c = sum_c + term(pr_lh, s_lh);
        if (mode2 == 2'd3) sum_c = sum_c + term(pr_ll, s_ll);
    end

    // Stage 3: result register; p keeps its last value across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p         <= '0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) p <= sum_c;
        end
    end
endmodule

// File: tb/tb_loba_pipe_mult.sv
// tb/tb_loba_pipe_mult.sv - self-checking bench for loba_pipe_mult
module tb_loba_pipe_mult;
    localparam int N = 16;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic [1:0]     mode = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*N-1:0] p;

    loba_pipe_mult #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int acc_cnt = 0;

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic void split(input longint unsigned x, output longint unsigned seg, output int sh);
        int k;
        seg = 0;
        sh  = 0;
        if (x == 0) return;
        k = 0;
        while ((x >> (k + 1)) != 0) k++;
        if (k >= W - 1) sh = k - W + 1;
        seg = (x >> sh) % (64'd1 << W);
    endfunction

    function automatic longint unsigned model(input longint unsigned x, input longint unsigned y, input int m);
        longint unsigned xh, xl, yh, yl, r;
        int sxh, sxl, syh, syl;
        split(x, xh, sxh);
        split(x % (64'd1 << sxh), xl, sxl);
        split(y, yh, syh);
        split(y % (64'd1 << syh), yl, syl);
        r = (xh * yh) << (sxh + syh);
        if (m >= 1) r += (xh * yl) << (sxh + syl);
        if (m >= 2) r += (xl * yh) << (sxl + syh);
        if (m == 3) r += (xl * yl) << (sxl + syl);
        return r;
    endfunction

    longint unsigned exp_q[$];
    longint unsigned ab_q[$];
    bit              prev_hold = 1'b0;
    logic [2*N-1:0]  prev_p = '0;

    // Compare process: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_p", p, prev_p);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    longint unsigned e, ab;
                    e  = exp_q.pop_front();
                    ab = ab_q.pop_front();
                    check("p", p, e);
                    check("p_le_ab", longint'(p <= ab), 1);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, mode));
                ab_q.push_back(longint'(a) * longint'(b));
                acc_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_p    = p;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    typedef struct { logic [N-1:0] va; logic [N-1:0] vb; logic [1:0] vm; } vec_t;
    vec_t vecs[$];

    initial begin
        int lat;
        int acc0;

        // reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // pin the model with hand-computed values
        check("m_ffff_m0", model(16'hFFFF, 16'hFFFF, 0), 64'hE1000000);
        check("m_ffff_m1", model(16'hFFFF, 16'hFFFF, 1), 64'hEF100000);
        check("m_5x3", model(5, 3, 0), 15);
        check("m_0xffff", model(0, 16'hFFFF, 3), 0);
        check("m_sweep0", model(16'h1234, 16'h0100, 0), 64'h120000);
        check("m_sweep1", model(16'h1234, 16'h0100, 1), 64'h120000);
        check("m_sweep2", model(16'h1234, 16'h0100, 2), 64'h123400);
        check("m_sweep3", model(16'h1234, 16'h0100, 3), 64'h123400);

        // latency of a single transaction
        a = 5; b = 3; mode = 2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 3);
        drain();

        // directed vectors back to back
        vecs = '{'{16'hFFFF, 16'hFFFF, 2'd0}, '{16'hFFFF, 16'hFFFF, 2'd1},
                 '{16'd5, 16'd3, 2'd0}, '{16'd5, 16'd3, 2'd3},
                 '{16'd0, 16'hFFFF, 2'd3}, '{16'h1234, 16'h0100, 2'd0},
                 '{16'h1234, 16'h0100, 2'd1}, '{16'h1234, 16'h0100, 2'd2},
                 '{16'h1234, 16'h0100, 2'd3}};
        foreach (vecs[i]) begin
            a = vecs[i].va; b = vecs[i].vb; mode = vecs[i].vm; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();

        // backpressure: exactly three accepted while output is stalled
        out_ready = 1'b0;
        acc0 = acc_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = N'($urandom); b = N'($urandom); mode = 2'($urandom);
            tick();
        end
        check("bp_accepted", acc_cnt - acc0, 3);
        check("bp_in_ready", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_release_valid", out_valid, 1);
            tick();
        end
        check("bp_after_empty", out_valid, 0);
        drain();

        // reset while three transactions are in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = N'($urandom); b = N'($urandom); mode = 2'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 0);
        exp_q.delete();
        ab_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_no_stale", out_valid, 0);

        // random regression with valid/ready toggling
        for (int i = 0; i < 400; i++) begin
            a = N'($urandom) & N'((32'd1 << $urandom_range(1, N)) - 1);
            b = N'($urandom) & N'((32'd1 << $urandom_range(1, N)) - 1);
            mode = 2'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
